// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, multiply/divide FSM states and shared constants
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MFHI = 4'd12;
  localparam logic [3:0] ALU_MFLO = 4'd13;
  localparam logic [3:0] ALU_MULT = 4'd14;
  localparam logic [3:0] ALU_DIV  = 4'd15;

  localparam int MD_CYCLES = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed MULT/DIV with HI/LO registers
module mult_div_unit
  import alu_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  output logic                 o_busy,
  output logic [NB_DATA-1:0]   o_hi,
  output logic [NB_DATA-1:0]   o_lo
);

  localparam int NB_CNT = $clog2(MD_CYCLES);

  md_state_e              state, state_next;
  logic [NB_CNT-1:0]      count;
  logic [2*NB_DATA-1:0]   acc, acc_in, acc_step;
  logic [NB_DATA-1:0]     opnd, opnd_in;
  logic                   is_div, div_in;
  logic                   neg_main, neg_rem, div_zero;
  logic                   md_op, start, is_div_op;
  logic [NB_DATA-1:0]     rs_mag, rt_mag;
  logic [NB_DATA:0]       mult_sum;
  logic [NB_DATA-1:0]     div_window;
  logic [2*NB_DATA-1:0]   prod_signed;
  logic [NB_DATA-1:0]     quot, rem;

  assign is_div_op = (i_alu_op == ALU_DIV);
  assign md_op     = (i_alu_op == ALU_MULT) || is_div_op;
  assign start     = (state == MD_IDLE) && md_op;
  assign o_busy    = start || (state != MD_IDLE);

  assign rs_mag = i_rs_data[NB_DATA-1] ? -i_rs_data : i_rs_data;
  assign rt_mag = i_rt_data[NB_DATA-1] ? -i_rt_data : i_rt_data;

  // The capture cycle performs step 0 on the fresh magnitudes, so BUSY needs only 31 more steps.
  always_comb begin
    acc_in  = acc;
    opnd_in = opnd;
    div_in  = is_div;
    if (start) begin
      acc_in  = {{NB_DATA{1'b0}}, rs_mag};
      opnd_in = rt_mag;
      div_in  = is_div_op;
    end
  end

  always_comb begin
    mult_sum   = {1'b0, acc_in[2*NB_DATA-1:NB_DATA]} + {1'b0, (acc_in[0] ? opnd_in : {NB_DATA{1'b0}})};
    div_window = acc_in[2*NB_DATA-2:NB_DATA-1];
    acc_step   = {mult_sum, acc_in[NB_DATA-1:1]};
    if (div_in) begin
      if (div_window >= opnd_in)
        acc_step = {div_window - opnd_in, acc_in[NB_DATA-2:0], 1'b1};
      else
        acc_step = {div_window, acc_in[NB_DATA-2:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (md_op) state_next = MD_BUSY;
      MD_BUSY: if (count == NB_CNT'(MD_CYCLES - 1)) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  assign prod_signed = neg_main ? -acc : acc;
  assign quot        = acc[NB_DATA-1:0];
  assign rem         = acc[2*NB_DATA-1:NB_DATA];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= MD_IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      o_hi     <= '0;
      o_lo     <= '0;
    end else if (i_enable) begin
      state <= state_next;
      case (state)
        MD_IDLE: begin
          if (md_op) begin
            acc      <= acc_step;
            opnd     <= opnd_in;
            is_div   <= div_in;
            count    <= NB_CNT'(1);
            div_zero <= is_div_op && (i_rt_data == '0);
            neg_main <= (i_rs_data[NB_DATA-1] ^ i_rt_data[NB_DATA-1]) && !(is_div_op && (i_rt_data == '0));
            neg_rem  <= i_rs_data[NB_DATA-1];
          end
        end
        MD_BUSY: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        MD_DONE: begin
          if (is_div) begin
            // A zero divisor leaves the dividend magnitude in rem, so HI recovers rs after the sign fix.
            o_lo <= div_zero ? {NB_DATA{1'b1}} : (neg_main ? -quot : quot);
            o_hi <= neg_rem ? -rem : rem;
          end else begin
            o_hi <= prod_signed[2*NB_DATA-1:NB_DATA];
            o_lo <= prod_signed[NB_DATA-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - MIPS execute stage: ALU, branch target, MULT/DIV stall, EX/MEM latch
module execute_unit
  import alu_pkg::*;
#(
  parameter int NB_ADDR           = 5,
  parameter int NB_DATA           = 2**NB_ADDR,
  parameter int NB_ALU_OP         = 4,
  parameter int NB_SHAMT          = 5,
  parameter int NB_LOAD_STORE_SEL = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [NB_DATA-1:0]           i_rs_data,
  input  logic [NB_DATA-1:0]           i_rt_data,
  input  logic [NB_DATA-1:0]           i_imm_ext,
  input  logic [NB_SHAMT-1:0]          i_shamt,
  input  logic [NB_ALU_OP-1:0]         i_alu_op,
  input  logic                         i_alu_src,
  input  logic [NB_DATA-1:0]           i_pc_plus4,
  input  logic [NB_DATA-1:0]           i_jump_addr,
  input  logic                         i_is_branch,
  input  logic                         i_is_jump,
  input  logic                         i_mem_wr_enb,
  input  logic                         i_mem_rd_enb,
  input  logic                         i_rf_wr_enb,
  input  logic                         i_rf_wr_data_src,
  input  logic [NB_LOAD_STORE_SEL-1:0] i_load_store_sel,
  input  logic [NB_ADDR-1:0]           i_rf_wr_addr,
  output logic                         o_stall,
  output logic [NB_DATA-1:0]           o_alu_result_ltchd,
  output logic [NB_DATA-1:0]           o_rt_data_ltchd,
  output logic [NB_DATA-1:0]           o_branch_addr_ltchd,
  output logic [NB_DATA-1:0]           o_jump_addr_ltchd,
  output logic                         o_alu_zero_ltchd,
  output logic                         o_is_branch_ltchd,
  output logic                         o_is_jump_ltchd,
  output logic                         o_mem_wr_enb_ltchd,
  output logic                         o_mem_rd_enb_ltchd,
  output logic                         o_rf_wr_enb_ltchd,
  output logic                         o_rf_wr_data_src_ltchd,
  output logic [NB_LOAD_STORE_SEL-1:0] o_load_store_sel_ltchd,
  output logic [NB_ADDR-1:0]           o_rf_wr_addr_ltchd
);

  logic [NB_DATA-1:0] operand_b;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] branch_addr;
  logic [NB_DATA-1:0] hi, lo;
  logic               md_busy;

  mult_div_unit #(
    .NB_DATA  (NB_DATA),
    .NB_ALU_OP(NB_ALU_OP)
  ) u_mult_div_unit (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_alu_op (i_alu_op),
    .i_rs_data(i_rs_data),
    .i_rt_data(i_rt_data),
    .o_busy   (md_busy),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  assign o_stall     = md_busy;
  assign operand_b   = i_alu_src ? i_imm_ext : i_rt_data;
  assign branch_addr = i_pc_plus4 + (i_imm_ext << 2);

  always_comb begin
    alu_result = '0;
    case (i_alu_op)
      ALU_ADD:  alu_result = i_rs_data + operand_b;
      ALU_SUB:  alu_result = i_rs_data - operand_b;
      ALU_AND:  alu_result = i_rs_data & operand_b;
      ALU_OR:   alu_result = i_rs_data | operand_b;
      ALU_XOR:  alu_result = i_rs_data ^ operand_b;
      ALU_NOR:  alu_result = ~(i_rs_data | operand_b);
      ALU_SLT:  alu_result = {{(NB_DATA-1){1'b0}}, ($signed(i_rs_data) < $signed(operand_b))};
      ALU_SLTU: alu_result = {{(NB_DATA-1){1'b0}}, (i_rs_data < operand_b)};
      ALU_SLL:  alu_result = i_rt_data << i_shamt;
      ALU_SRL:  alu_result = i_rt_data >> i_shamt;
      ALU_SRA:  alu_result = $unsigned($signed(i_rt_data) >>> i_shamt);
      ALU_LUI:  alu_result = operand_b << 16;
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  // Stalled cycles push a bubble downstream; the MULT/DIV instruction itself leaves this way.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_alu_result_ltchd     <= '0;
      o_rt_data_ltchd        <= '0;
      o_branch_addr_ltchd    <= '0;
      o_jump_addr_ltchd      <= '0;
      o_alu_zero_ltchd       <= 1'b0;
      o_is_branch_ltchd      <= 1'b0;
      o_is_jump_ltchd        <= 1'b0;
      o_mem_wr_enb_ltchd     <= 1'b0;
      o_mem_rd_enb_ltchd     <= 1'b0;
      o_rf_wr_enb_ltchd      <= 1'b0;
      o_rf_wr_data_src_ltchd <= 1'b0;
      o_load_store_sel_ltchd <= '0;
      o_rf_wr_addr_ltchd     <= '0;
    end else if (i_enable) begin
      if (md_busy) begin
        o_alu_result_ltchd     <= '0;
        o_rt_data_ltchd        <= '0;
        o_branch_addr_ltchd    <= '0;
        o_jump_addr_ltchd      <= '0;
        o_alu_zero_ltchd       <= 1'b0;
        o_is_branch_ltchd      <= 1'b0;
        o_is_jump_ltchd        <= 1'b0;
        o_mem_wr_enb_ltchd     <= 1'b0;
        o_mem_rd_enb_ltchd     <= 1'b0;
        o_rf_wr_enb_ltchd      <= 1'b0;
        o_rf_wr_data_src_ltchd <= 1'b0;
        o_load_store_sel_ltchd <= '0;
        o_rf_wr_addr_ltchd     <= '0;
      end else begin
        o_alu_result_ltchd     <= alu_result;
        o_rt_data_ltchd        <= i_rt_data;
        o_branch_addr_ltchd    <= branch_addr;
        o_jump_addr_ltchd      <= i_jump_addr;
        o_alu_zero_ltchd       <= (alu_result == '0);
        o_is_branch_ltchd      <= i_is_branch;
        o_is_jump_ltchd        <= i_is_jump;
        o_mem_wr_enb_ltchd     <= i_mem_wr_enb;
        o_mem_rd_enb_ltchd     <= i_mem_rd_enb;
        o_rf_wr_enb_ltchd      <= i_rf_wr_enb;
        o_rf_wr_data_src_ltchd <= i_rf_wr_data_src;
        o_load_store_sel_ltchd <= i_load_store_sel;
        o_rf_wr_addr_ltchd     <= i_rf_wr_addr;
      end
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed scoreboard bench for execute_unit
module tb_execute_unit;
  import alu_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset, i_enable;
  logic [31:0] i_rs_data, i_rt_data, i_imm_ext, i_pc_plus4, i_jump_addr;
  logic [4:0]  i_shamt, i_rf_wr_addr;
  logic [3:0]  i_alu_op;
  logic        i_alu_src, i_is_branch, i_is_jump, i_mem_wr_enb, i_mem_rd_enb;
  logic        i_rf_wr_enb, i_rf_wr_data_src;
  logic [1:0]  i_load_store_sel;
  logic        o_stall;
  logic [31:0] o_alu_result_ltchd, o_rt_data_ltchd, o_branch_addr_ltchd, o_jump_addr_ltchd;
  logic        o_alu_zero_ltchd, o_is_branch_ltchd, o_is_jump_ltchd, o_mem_wr_enb_ltchd;
  logic        o_mem_rd_enb_ltchd, o_rf_wr_enb_ltchd, o_rf_wr_data_src_ltchd;
  logic [1:0]  o_load_store_sel_ltchd;
  logic [4:0]  o_rf_wr_addr_ltchd;

  execute_unit dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm_ext(i_imm_ext),
    .i_shamt(i_shamt), .i_alu_op(i_alu_op), .i_alu_src(i_alu_src),
    .i_pc_plus4(i_pc_plus4), .i_jump_addr(i_jump_addr),
    .i_is_branch(i_is_branch), .i_is_jump(i_is_jump),
    .i_mem_wr_enb(i_mem_wr_enb), .i_mem_rd_enb(i_mem_rd_enb),
    .i_rf_wr_enb(i_rf_wr_enb), .i_rf_wr_data_src(i_rf_wr_data_src),
    .i_load_store_sel(i_load_store_sel), .i_rf_wr_addr(i_rf_wr_addr),
    .o_stall(o_stall),
    .o_alu_result_ltchd(o_alu_result_ltchd), .o_rt_data_ltchd(o_rt_data_ltchd),
    .o_branch_addr_ltchd(o_branch_addr_ltchd), .o_jump_addr_ltchd(o_jump_addr_ltchd),
    .o_alu_zero_ltchd(o_alu_zero_ltchd), .o_is_branch_ltchd(o_is_branch_ltchd),
    .o_is_jump_ltchd(o_is_jump_ltchd), .o_mem_wr_enb_ltchd(o_mem_wr_enb_ltchd),
    .o_mem_rd_enb_ltchd(o_mem_rd_enb_ltchd), .o_rf_wr_enb_ltchd(o_rf_wr_enb_ltchd),
    .o_rf_wr_data_src_ltchd(o_rf_wr_data_src_ltchd),
    .o_load_store_sel_ltchd(o_load_store_sel_ltchd),
    .o_rf_wr_addr_ltchd(o_rf_wr_addr_ltchd)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
    logic [31:0] baddr;
    logic [31:0] rt;
    logic [4:0]  waddr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_hi = '0, model_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic src, input logic [4:0] sh,
                       input logic [31:0] pc, input logic br);
    i_alu_op = op; i_rs_data = rs; i_rt_data = rt; i_imm_ext = imm; i_alu_src = src;
    i_shamt = sh; i_pc_plus4 = pc; i_is_branch = br; i_rf_wr_enb = 1'b1;
    i_rf_wr_addr = rs[4:0] ^ 5'd9;
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm, input logic src,
                       input logic [4:0] sh, input logic [31:0] pc, input logic br,
                       input logic [31:0] exp_res);
    exp_t e;
    drive(op, rs, rt, imm, src, sh, pc, br);
    e.tag = tag; e.res = exp_res; e.zero = (exp_res == 32'd0);
    e.baddr = pc + (imm << 2); e.rt = rt; e.waddr = rs[4:0] ^ 5'd9;
    sb.push_back(e);
    @(posedge i_clock); #1;
    e = sb.pop_front();
    chk({e.tag, ".result"}, o_alu_result_ltchd, e.res);
    chk({e.tag, ".zero"}, {31'd0, o_alu_zero_ltchd}, {31'd0, e.zero});
    chk({e.tag, ".baddr"}, o_branch_addr_ltchd, e.baddr);
    chk({e.tag, ".rt"}, o_rt_data_ltchd, e.rt);
    chk({e.tag, ".wr"}, {26'd0, o_rf_wr_enb_ltchd, o_rf_wr_addr_ltchd}, {26'd0, 1'b1, e.waddr});
  endtask

  // Presents a MULT/DIV for 33 enabled edges (plus an optional enable-low gap) and updates the HI/LO model.
  task automatic md_run(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int pause_at, input int pause_len);
    int     en_edges = 0, paused = 0, n_high = 0, bad_bubbles = 0;
    int     a, b;
    longint p;
    a = rs; b = rt;
    if (op == ALU_MULT) begin
      p = longint'(a) * longint'(b);
      model_hi = p[63:32]; model_lo = p[31:0];
    end else if (b == 0) begin
      model_hi = rs; model_lo = 32'hFFFFFFFF;
    end else begin
      model_lo = a / b; model_hi = a % b;
    end
    drive(op, rs, rt, 32'd0, 1'b0, 5'd0, 32'h40, 1'b0);
    while (en_edges < 33) begin
      if (en_edges == pause_at && paused < pause_len) begin
        i_enable = 1'b0; paused++;
      end else begin
        i_enable = 1'b1; en_edges++;
      end
      #1;
      if (o_stall === 1'b1) n_high++;
      @(posedge i_clock); #1;
      if (o_alu_result_ltchd !== 32'd0 || o_rf_wr_enb_ltchd !== 1'b0 || o_branch_addr_ltchd !== 32'd0)
        bad_bubbles++;
    end
    i_enable = 1'b1;
    drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    chk({tag, ".stall_after"}, {31'd0, o_stall}, 32'd0);
    chk({tag, ".stall_cycles"}, n_high, 33 + pause_len);
    chk({tag, ".bubbles"}, bad_bubbles, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_jump_addr = 32'h0040_0800; i_is_jump = 1'b0;
    i_mem_wr_enb = 1'b0; i_mem_rd_enb = 1'b0; i_rf_wr_data_src = 1'b0; i_load_store_sel = 2'd0;
    drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (2) @(posedge i_clock);
    #1;
    chk("reset.result", o_alu_result_ltchd, 32'd0);
    chk("reset.stall", {31'd0, o_stall}, 32'd0);
    chk("reset.ctrl", {26'd0, o_rf_wr_enb_ltchd, o_rf_wr_addr_ltchd}, 32'd0);
    i_reset = 1'b0;

    issue("add_wrap", ALU_ADD, 32'h7FFFFFFF, 32'd3, 32'd1, 1'b1, 5'd0, 32'h10, 1'b0, 32'h80000000);
    issue("beq_sub", ALU_SUB, 32'd5, 32'd5, 32'd4, 1'b0, 5'd0, 32'h100, 1'b1, 32'd0);
    chk("beq.is_branch", {31'd0, o_is_branch_ltchd}, 32'd1);
    issue("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'h20, 1'b0, 32'd1);
    issue("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'h24, 1'b0, 32'd0);
    issue("sra", ALU_SRA, 32'd1, 32'h80000000, 32'd0, 1'b0, 5'd4, 32'h28, 1'b0, 32'hF8000000);
    issue("lui", ALU_LUI, 32'd2, 32'd0, 32'h1234, 1'b1, 5'd0, 32'h2C, 1'b0, 32'h12340000);
    issue("nor", ALU_NOR, 32'h0F0F0000, 32'h000000F0, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h30, 1'b0, 32'hF0F0FF0F);

    i_enable = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge i_clock); #1;
    chk("enable_low.hold", o_alu_result_ltchd, 32'hF0F0FF0F);
    i_enable = 1'b1;

    md_run("mult", ALU_MULT, 32'hFFFFFFFD, 32'd7, 40, 0);
    issue("mult.mflo", ALU_MFLO, 32'd3, 32'd0, 32'd0, 1'b0, 5'd0, 32'h50, 1'b0, model_lo);
    chk("mult.lo_const", model_lo, 32'hFFFFFFEB);
    issue("mult.mfhi", ALU_MFHI, 32'd4, 32'd0, 32'd0, 1'b0, 5'd0, 32'h54, 1'b0, model_hi);

    md_run("div", ALU_DIV, 32'hFFFFFFF9, 32'd2, 40, 0);
    issue("div.mflo", ALU_MFLO, 32'd5, 32'd0, 32'd0, 1'b0, 5'd0, 32'h60, 1'b0, 32'hFFFFFFFD);
    issue("div.mfhi", ALU_MFHI, 32'd6, 32'd0, 32'd0, 1'b0, 5'd0, 32'h64, 1'b0, 32'hFFFFFFFF);

    md_run("mult_pause", ALU_MULT, 32'd12345, 32'hFFFFFD5A, 10, 5);
    issue("pause.mflo", ALU_MFLO, 32'd7, 32'd0, 32'd0, 1'b0, 5'd0, 32'h70, 1'b0, model_lo);
    issue("pause.mfhi", ALU_MFHI, 32'd8, 32'd0, 32'd0, 1'b0, 5'd0, 32'h74, 1'b0, model_hi);

    md_run("div0", ALU_DIV, 32'd9, 32'd0, 40, 0);
    issue("div0.mflo", ALU_MFLO, 32'd9, 32'd0, 32'd0, 1'b0, 5'd0, 32'h80, 1'b0, 32'hFFFFFFFF);
    issue("div0.mfhi", ALU_MFHI, 32'd10, 32'd0, 32'd0, 1'b0, 5'd0, 32'h84, 1'b0, 32'd9);

    drive(ALU_MULT, 32'd100, 32'd200, 32'd0, 1'b0, 5'd0, 32'h90, 1'b0);
    repeat (11) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    chk("midreset.stall", {31'd0, o_stall}, 32'd0);
    chk("midreset.result", o_alu_result_ltchd, 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    issue("midreset.mfhi", ALU_MFHI, 32'd11, 32'd0, 32'd0, 1'b0, 5'd0, 32'hA0, 1'b0, 32'd0);
    issue("midreset.mflo", ALU_MFLO, 32'd12, 32'd0, 32'd0, 1'b0, 5'd0, 32'hA4, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
